// File: rtl/seq_match_ctrl_if.sv
// Bundles the control, configuration, stream and status signals of seq_match_ctrl.
//   master : drives start/stop, stream bits, configuration and count_clr; observes status.
//   slave  : the controller side; observes the inputs and drives y/busy/cfg_ack/cfg_err/count.
interface seq_match_ctrl_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
);
  localparam int unsigned LW = $clog2(W + 1);

  logic          start;
  logic          stop;
  logic          in_valid;
  logic          in_bit;
  logic          cfg_load;
  logic [W-1:0]  cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic          count_clr;
  logic          y;
  logic          busy;
  logic          cfg_ack;
  logic          cfg_err;
  logic [CW-1:0] match_count;

  modport master (
    output start, stop, in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
           count_clr,
    input  y, busy, cfg_ack, cfg_err, match_count
  );

  modport slave (
    input  start, stop, in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
           count_clr,
    output y, busy, cfg_ack, cfg_err, match_count
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Programmable serial sequence detector with run/stop control and a saturating match counter.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : seq_match_ctrl_if.slave
//         start/stop      - IDLE<->RUN requests (stop wins)
//         in_valid/in_bit - serial stream
//         cfg_*           - pattern (bit [len-1] received first), length, overlap mode
//         count_clr       - synchronous counter clear (wins over a coincident match)
//         y               - combinational Mealy match
//         busy, cfg_ack, cfg_err, match_count - registered status
module seq_match_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16
) (
  input logic              clk,
  input logic              rst,
  seq_match_ctrl_if.slave  bus
);
  localparam int unsigned LW = $clog2(W + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic          ovl_q;
  logic [W-2:0]  hist_q;
  logic [LW-1:0] fill_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          cfg_ack_q;
  logic          cfg_err_q;

  logic [W-1:0]  window;
  logic [W-1:0]  mask;
  logic          len_ok;
  logic          match;

  always_comb begin
    window = {hist_q, bus.in_bit};
    // len_q == W shifts the 1 out entirely, so the subtraction yields an all-ones mask.
    mask   = (W'(1) << len_q) - W'(1);
    match  = (state_q == StRun) && bus.in_valid && (fill_q >= len_q - LW'(1)) &&
             ((window & mask) == (pat_q & mask));
    len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= W'(4'b0110);
      len_q     <= LW'(4);
      ovl_q     <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;

      if (bus.cfg_load) begin
        if ((state_q == StIdle) && len_ok) begin
          pat_q     <= bus.cfg_pattern;
          len_q     <= bus.cfg_len;
          ovl_q     <= bus.cfg_overlap;
          cfg_ack_q <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.stop) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            fill_q  <= '0;
          end
        end
        StRun: begin
          if (bus.stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            fill_q  <= '0;
          end else if (bus.in_valid) begin
            if (match && !ovl_q) begin
              // Non-overlapping mode: the next match must be built from fresh bits only.
              fill_q <= '0;
            end else begin
              hist_q <= {hist_q[W-3:0], bus.in_bit};
              fill_q <= (fill_q == LW'(W - 1)) ? fill_q : fill_q + LW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (bus.count_clr) begin
        cnt_q <= '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.y           = match;
  assign bus.busy        = busy_q;
  assign bus.cfg_ack     = cfg_ack_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed, table-driven bench for seq_match_ctrl (W=8, CW=4 so saturation is reachable).
module tb_seq_match_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst;

  seq_match_ctrl_if #(.W(W), .CW(CW)) bus ();

  seq_match_ctrl #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       stop;
    logic       iv;
    logic       ib;
    logic       cl;
    logic [7:0] cp;
    logic [3:0] clen;
    logic       co;
    logic       clr;
    logic       ey;
    logic       ebusy;
    logic       eack;
    logic       eerr;
    logic [3:0] ecnt;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic start, input logic stop, input logic iv,
                              input logic ib, input logic cl, input logic [7:0] cp,
                              input logic [3:0] clen, input logic co, input logic clr,
                              input logic ey, input logic ebusy, input logic eack,
                              input logic eerr, input logic [3:0] ecnt);
    vec_t v;
    v.start = start; v.stop = stop; v.iv = iv; v.ib = ib; v.cl = cl; v.cp = cp;
    v.clen = clen; v.co = co; v.clr = clr; v.ey = ey; v.ebusy = ebusy; v.eack = eack;
    v.eerr = eerr; v.ecnt = ecnt;
    return v;
  endfunction

  // Stream bit while running.
  task automatic b(input logic ib, input logic ey, input logic [3:0] cnt);
    tbl.push_back(mk(0, 0, 1, ib, 0, 0, 0, 0, 0, ey, 1, 0, 0, cnt));
  endtask
  task automatic gap(input logic [3:0] cnt);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cnt));
  endtask
  task automatic go(input logic [3:0] cnt);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cnt));
  endtask
  task automatic halt(input logic clr, input logic [3:0] cnt);
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, clr, 0, 0, 0, 0, cnt));
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                     input logic ebusy, input logic ack, input logic err,
                     input logic [3:0] cnt);
    tbl.push_back(mk(0, 0, 0, 0, 1, p, l, o, 0, 0, ebusy, ack, err, cnt));
  endtask

  task automatic drive(input vec_t v);
    bus.start       = v.start;
    bus.stop        = v.stop;
    bus.in_valid    = v.iv;
    bus.in_bit      = v.ib;
    bus.cfg_load    = v.cl;
    bus.cfg_pattern = v.cp;
    bus.cfg_len     = v.clen;
    bus.cfg_overlap = v.co;
    bus.count_clr   = v.clr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1 chk("y", idx, 32'(bus.y), 32'(v.ey));
    @(posedge clk);
    #1;
    chk("busy", idx, 32'(bus.busy), 32'(v.ebusy));
    chk("cfg_ack", idx, 32'(bus.cfg_ack), 32'(v.eack));
    chk("cfg_err", idx, 32'(bus.cfg_err), 32'(v.eerr));
    chk("match_count", idx, 32'(bus.match_count), 32'(v.ecnt));
  endtask

  task automatic run_tbl(input int base);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_y", 0, 32'(bus.y), 0);
    chk("rst_busy", 0, 32'(bus.busy), 0);
    chk("rst_ack", 0, 32'(bus.cfg_ack), 0);
    chk("rst_err", 0, 32'(bus.cfg_err), 0);
    chk("rst_cnt", 0, 32'(bus.match_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Default 0110/4/overlap: matches on bits 4 and 7.
    go(0);
    b(0, 0, 0); b(1, 0, 0); b(1, 0, 0); b(0, 1, 1); b(1, 0, 1); b(1, 0, 1); b(0, 1, 2);
    halt(1, 0);
    // Non-overlapping: only bit 4 matches.
    cfg(8'b0110, 4, 0, 0, 1, 0, 0);
    go(0);
    b(0, 0, 0); b(1, 0, 0); b(1, 0, 0); b(0, 1, 1); b(1, 0, 1); b(1, 0, 1); b(0, 0, 1);
    halt(0, 1);
    // Gap cycles between valid bits.
    go(1);
    b(0, 0, 1); gap(1); b(1, 0, 1); gap(1); b(1, 0, 1); gap(1); b(0, 1, 2);
    halt(0, 2);
    // New pattern 1011, then a rejected load during RUN leaves it in place.
    cfg(8'b1011, 4, 1, 0, 1, 0, 2);
    go(2);
    b(1, 0, 2); b(0, 0, 2); b(1, 0, 2); b(1, 1, 3);
    cfg(8'b0000, 4, 0, 1, 0, 1, 3);
    b(0, 0, 3); b(1, 0, 3); b(1, 1, 4);
    halt(0, 4);
    // Illegal lengths in IDLE; ignored stop, stop beats start.
    cfg(8'b0, 0, 0, 0, 0, 1, 4);
    cfg(8'hff, 9, 0, 0, 0, 1, 4);
    halt(0, 4);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    // Pattern still 1011; stop coincident with a match counts it and clears fill.
    go(4);
    b(1, 0, 4); b(0, 0, 4); b(1, 0, 4); b(1, 1, 5); b(0, 0, 5); b(1, 0, 5);
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6));
    go(6);
    b(0, 0, 6); b(1, 0, 6); b(1, 0, 6);
    halt(0, 6);
    // Load len=1 together with start: active from the first RUN bit; saturate then clear.
    tbl.push_back(mk(1, 0, 0, 0, 1, 8'h01, 1, 1, 0, 0, 1, 1, 0, 6));
    for (int k = 7; k <= 15; k++) b(1, 1, 4'(k));
    b(1, 1, 15);
    b(0, 0, 15);
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    b(1, 1, 1);
    halt(0, 1);
    run_tbl(1);

    // Reload 0110 and build a partial match, then reset mid-stream.
    cfg(8'b0110, 4, 1, 0, 1, 0, 1);
    go(1);
    b(0, 0, 1); b(1, 0, 1); b(1, 0, 1);
    run_tbl(100);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b0;
    #1 chk("pre_rst_y", 200, 32'(bus.y), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_y", 201, 32'(bus.y), 0);
    chk("mid_rst_busy", 201, 32'(bus.busy), 0);
    chk("mid_rst_cnt", 201, 32'(bus.match_count), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Config back to 0110/4/overlap and history empty: full sequence needed.
    go(0);
    b(0, 0, 0); b(1, 0, 0); b(1, 0, 0); b(0, 1, 1);
    halt(0, 1);
    run_tbl(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial sequence-detector controller. It sequences a Mealy-style pattern matcher over a one-bit serial stream and exposes a configuration port for pattern, length and overlap mode. It also provides run/stop control and a saturating match counter. It sits between the serial input source and any consumer of match events, and supersedes hard-coded single-pattern detectors in the FSM library.

## Interface
Parameters:
- `W`, default 8: maximum pattern length in bits (≥ 4).
- `CW`, default 16: match-counter width.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request IDLE→RUN.
- `stop`, in, 1: request RUN→IDLE.
- `in_valid`, in, 1: `in_bit` is a stream bit this cycle.
- `in_bit`, in, 1: serial data bit.
- `cfg_load`, in, 1: load configuration this cycle.
- `cfg_pattern`, in, W: pattern. Bit `[len-1]` is the first bit received; bit `[0]` is the last.
- `cfg_len`, in, $clog2(W+1): pattern length, legal range 1..W.
- `cfg_overlap`, in, 1: 1 = overlapping matches allowed.
- `count_clr`, in, 1: synchronous clear of the match counter.
- `y`, out, 1: Mealy match output, combinational.
- `busy`, out, 1: registered; high in RUN.
- `cfg_ack`, out, 1: registered one-cycle pulse; configuration accepted.
- `cfg_err`, out, 1: registered one-cycle pulse; configuration rejected.
- `match_count`, out, CW: registered saturating match count.

## Operation
- States: IDLE, RUN. `busy` = (state == RUN).
- Internal registers:
  - `pat` (W), `len`, `ovl`.
  - `hist` (W-1): shift register of previously accepted bits, newest at bit 0.
  - `fill`: number of valid bits in `hist`, saturating at W-1.
- Match condition, evaluated combinationally:
  - `match` = RUN & `in_valid` & (`fill` ≥ `len`-1) & ({`hist`,`in_bit`} masked to low `len` bits == `pat` masked to low `len` bits).
  - `y` = `match`.
- Stream handling in RUN, on a cycle with `in_valid`=1:
  - `hist` ← {`hist`[W-3:0], `in_bit`}.
  - `fill` ← min(`fill`+1, W-1).
  - Exception: if `match` & !`ovl`, then `fill` ← 0; `hist` contents are don't-care.
- Stream handling on cycles with `in_valid`=0, or in IDLE: `hist` and `fill` hold. `y` = 0.
- Transitions:
  - IDLE→RUN when `start` & !`stop`; `fill` ← 0 on entry.
  - RUN→IDLE when `stop`; `fill` ← 0.
  - `stop` has priority over `start`.
  - `start` in RUN and `stop` in IDLE are ignored.
- Configuration:
  - `cfg_load` in IDLE with 1 ≤ `cfg_len` ≤ W: `pat`/`len`/`ovl` updated, `cfg_ack` pulses.
  - `cfg_load` in RUN, or with `cfg_len` = 0 or > W: registers unchanged, `cfg_err` pulses.
  - `cfg_load` coincident with `start` in IDLE: configuration is accepted and the block enters RUN with the new configuration in effect from the first RUN cycle.
- Counter:
  - `match_count` increments on each `match`, saturating at 2^CW-1.
  - `count_clr` has priority: a coincident match is not counted.
  - `match_count` is retained across stop/start.

## Timing
- Reset values:
  - state IDLE, `busy` 0.
  - `pat` = 0110 (zero-extended), `len` 4, `ovl` 1.
  - `hist` 0, `fill` 0, `match_count` 0.
  - `cfg_ack` 0, `cfg_err` 0, `y` 0.
- Latency:
  - `y`: zero cycles; it asserts in the same cycle as the final pattern bit is presented.
  - `match_count`: updates at the edge closing that cycle.
  - `cfg_ack`/`cfg_err`: high in the cycle after `cfg_load`, for exactly one cycle.
  - `busy`: rises the cycle after `start` and falls the cycle after `stop`.
- A stop in the same cycle as a match: the match is reported on `y` and counted; `fill` is then cleared.
- Reset mid-RUN:
  - All registers return to reset values immediately; `y` drops asynchronously.
  - The configuration reverts to 0110 / 4 / overlap.
- `len` = 1: every valid bit equal to `pat[0]` matches, independent of `fill`.

## Test plan
- Reset, then `start`, then stream 0,1,1,0,1,1,0 with `in_valid`=1 each cycle → `y` high on bits 4 and 7; `match_count` = 2.
- Load `cfg_overlap`=0 (pattern 0110, len 4), `start`, same stream → `y` high on bit 4 only; `match_count` = 1.
- Stream 0,1,1,0 with an `in_valid`=0 gap cycle between each bit → `y` = 0 in the gap cycles; `y` high only on the cycle presenting the 4th valid bit.
- In IDLE, load pattern 1011 len 4 → `cfg_ack` pulse. Then `start` with stream 1,0,1,1 → one match.
  - `cfg_load` during RUN → `cfg_err` pulse; pattern unchanged.
  - `cfg_len`=0 in IDLE → `cfg_err` pulse.
- Drive the counter to 2^CW-1, then one more match → `match_count` stays at 2^CW-1. Match coincident with `count_clr` → `match_count` = 0.
- Assert `rst` mid-stream while in RUN with a partial match in `hist` → `y`, `busy` and `match_count` go to 0 immediately. After release and `start`, a complete 0110 is required before the next match.
